// File: rtl/div_sequencer_if.sv
// rtl/div_sequencer_if.sv - EX-stage <-> divider handshake bundle (annul_i only with DIV_ANNUL_EN)
interface div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic                 signed_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
`ifdef DIV_ANNUL_EN
    logic                 annul_i;
`endif
    logic                 stall_o;
    logic                 ready_o;
    logic                 write_hilo_o;
    logic [2*WIDTH-1:0]   result_o;
    logic                 div_by_zero_o;

    modport master (
`ifdef DIV_ANNUL_EN
        output annul_i,
`endif
        output start_i, signed_i, opdata1_i, opdata2_i,
        input  stall_o, ready_o, write_hilo_o, result_o, div_by_zero_o
    );

    modport slave (
`ifdef DIV_ANNUL_EN
        input  annul_i,
`endif
        input  start_i, signed_i, opdata1_i, opdata2_i,
        output stall_o, ready_o, write_hilo_o, result_o, div_by_zero_o
    );
endinterface

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle DIV/DIVU sequencer with radix-2 restoring divider
// Optional flush input enabled by defining DIV_ANNUL_EN.
module div_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    div_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DZERO = 2'd1,
        S_ON    = 2'd2,
        S_END   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [2*WIDTH:0]       rem_q;
    logic [2*WIDTH:0]       rem_d;
    logic [WIDTH-1:0]       divisor_q;
    logic [WIDTH-1:0]       dividend_q;
    logic                   neg_quot_q;
    logic                   neg_rem_q;
    logic                   dz_q;

    logic                   annul;
    logic                   accept;
    logic                   last_iter;
    logic [WIDTH-1:0]       mag_a;
    logic [WIDTH-1:0]       mag_b;
    logic [2*WIDTH:0]       shifted;
    logic [WIDTH:0]         upper;

`ifdef DIV_ANNUL_EN
    assign annul = bus.annul_i;
`else
    assign annul = 1'b0;
`endif

    assign accept    = (state_q == S_IDLE) && bus.start_i && !annul;
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // Magnitudes are only meaningful for DIV; DIVU passes operands through.
    assign mag_a = (bus.signed_i && bus.opdata1_i[WIDTH-1]) ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
    assign mag_b = (bus.signed_i && bus.opdata2_i[WIDTH-1]) ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;

    // One restoring step: shift, trial-subtract on the upper WIDTH+1 bits.
    always_comb begin
        shifted = rem_q << 1;
        upper   = shifted[2*WIDTH:WIDTH];
        rem_d   = shifted;
        if (upper >= {1'b0, divisor_q}) begin
            rem_d = {upper - {1'b0, divisor_q}, shifted[WIDTH-1:1], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (bus.opdata2_i == '0) ? S_DZERO : S_ON;
                end
            end
            S_DZERO: state_d = annul ? S_IDLE : S_END;
            S_ON: begin
                if (annul) begin
                    state_d = S_IDLE;
                end else if (last_iter) begin
                    state_d = S_END;
                end
            end
            S_END:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
            dividend_q <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
        end else if (accept) begin
            cnt_q      <= '0;
            rem_q      <= {{(WIDTH+1){1'b0}}, mag_a};
            divisor_q  <= mag_b;
            dividend_q <= bus.opdata1_i;
            neg_quot_q <= bus.signed_i && (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
            neg_rem_q  <= bus.signed_i && bus.opdata1_i[WIDTH-1];
            dz_q       <= (bus.opdata2_i == '0);
        end else if (state_q == S_ON) begin
            cnt_q <= cnt_q + 1'b1;
            rem_q <= rem_d;
        end
    end

    logic [WIDTH-1:0]   quot_raw, rem_raw;
    logic               stall_c, ready_c, dz_c;
    logic [2*WIDTH-1:0] result_c;

    assign quot_raw = rem_q[WIDTH-1:0];
    assign rem_raw  = rem_q[2*WIDTH-1:WIDTH];

    always_comb begin
        stall_c  = 1'b0;
        ready_c  = 1'b0;
        dz_c     = 1'b0;
        result_c = '0;
        case (state_q)
            S_IDLE:  stall_c = accept && !rst;
            S_DZERO: stall_c = !annul;
            S_ON:    stall_c = !annul;
            S_END: begin
                ready_c = 1'b1;
                dz_c    = dz_q;
                if (dz_q) begin
                    result_c = {dividend_q, {WIDTH{1'b1}}};
                end else begin
                    result_c = {neg_rem_q  ? (~rem_raw  + 1'b1) : rem_raw,
                                neg_quot_q ? (~quot_raw + 1'b1) : quot_raw};
                end
            end
            default: ;
        endcase
    end

    assign bus.stall_o       = stall_c;
    assign bus.ready_o       = ready_c;
    assign bus.write_hilo_o  = ready_c;
    assign bus.result_o      = result_c;
    assign bus.div_by_zero_o = dz_c;
endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - directed and random checks of div_sequencer against an arithmetic model
module tb_div_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    div_sequencer_if #(.WIDTH(32)) bus ();

    div_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {div_by_zero, HI, LO} computed directly from the arithmetic rules.
    function automatic logic [64:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, q, r;
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (!s) return {1'b0, a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {1'b0, r, q};
    endfunction

    // Called just after a negedge; leaves start_i high so a following call is back-to-back.
    task automatic run_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [64:0] exp;
        int lat, got;
        logic stall_ok, strobe_ok, idle_zero_ok;
        logic [63:0] res;
        logic dz;
        exp          = model(s, a, b);
        lat          = (b == 32'd0) ? 2 : 33;
        got          = -1;
        stall_ok     = 1'b1;
        strobe_ok    = 1'b1;
        idle_zero_ok = 1'b1;
        res          = '0;
        dz           = 1'b0;
        bus.start_i   = 1'b1;
        bus.signed_i  = s;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        for (int c = 0; c <= 40 && got < 0; c++) begin
            #1;
            if (bus.stall_o !== (c < lat)) stall_ok = 1'b0;
            if (bus.write_hilo_o !== bus.ready_o) strobe_ok = 1'b0;
            if (bus.ready_o === 1'b1) begin
                got = c;
                res = bus.result_o;
                dz  = bus.div_by_zero_o;
            end else if (bus.result_o !== 64'd0 || bus.div_by_zero_o !== 1'b0) begin
                idle_zero_ok = 1'b0;
            end
            @(negedge clk);
            if (c == 0) begin
                bus.opdata1_i = $urandom;
                bus.opdata2_i = $urandom;
                bus.signed_i  = 1'($urandom);
            end
        end
        chk({tag, "_latency"}, 64'(got), 64'(lat));
        chk({tag, "_result"}, res, exp[63:0]);
        chk({tag, "_dz"}, 64'(dz), 64'(exp[64]));
        chk({tag, "_stall"}, 64'(stall_ok), 64'd1);
        chk({tag, "_hilo_strobe"}, 64'(strobe_ok), 64'd1);
        chk({tag, "_quiet_outputs"}, 64'(idle_zero_ok), 64'd1);
    endtask

    initial begin
        logic [31:0] a, b;
        logic s;
        int hilo_seen;
        bus.start_i   = 1'b1;
        bus.signed_i  = 1'b0;
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
`ifdef DIV_ANNUL_EN
        bus.annul_i   = 1'b0;
`endif
        @(negedge clk);
        #1;
        chk("rst_stall", 64'(bus.stall_o), 64'd0);
        chk("rst_ready", 64'(bus.ready_o), 64'd0);
        chk("rst_result", bus.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.start_i = 1'b0;
        #1;
        chk("idle_stall", 64'(bus.stall_o), 64'd0);
        chk("idle_hilo", 64'(bus.write_hilo_o), 64'd0);
        @(negedge clk);

        run_op("divu_100_7", 1'b0, 32'd100, 32'd7);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_5_0", 1'b0, 32'd5, 32'd0);
        run_op("div_m9_0", 1'b1, 32'hFFFF_FFF7, 32'd0);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);

        // Reset in the middle of a divide.
        bus.start_i   = 1'b1;
        bus.signed_i  = 1'b0;
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        for (int c = 0; c < 10; c++) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_stall", 64'(bus.stall_o), 64'd0);
        chk("midrst_ready", 64'(bus.ready_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.start_i = 1'b0;
        #1;
        chk("postrst_stall", 64'(bus.stall_o), 64'd0);
        @(negedge clk);
        run_op("divu_9_3", 1'b0, 32'd9, 32'd3);

`ifdef DIV_ANNUL_EN
        bus.start_i   = 1'b1;
        bus.signed_i  = 1'b0;
        bus.opdata1_i = 32'd1000;
        bus.opdata2_i = 32'd3;
        hilo_seen     = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (bus.write_hilo_o === 1'b1) hilo_seen++;
            @(negedge clk);
        end
        bus.annul_i = 1'b1;
        #1;
        chk("annul_stall", 64'(bus.stall_o), 64'd0);
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        #1;
        chk("annul_idle_stall", 64'(bus.stall_o), 64'd0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (bus.write_hilo_o === 1'b1) hilo_seen++;
        end
        chk("annul_no_hilo", 64'(hilo_seen), 64'd0);
        @(negedge clk);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b1;
        #1;
        chk("annul_blocks_start", 64'(bus.stall_o), 64'd0);
        @(negedge clk);
        bus.annul_i = 1'b0;
        #1;
        chk("annul_idle_after_block", 64'(bus.stall_o), 64'd1);
        run_op("after_annul", 1'b1, 32'hFFFF_FF00, 32'd16);
`else
        hilo_seen = 0;
        chk("no_annul_hilo_init", 64'(hilo_seen), 64'd0 + 64'(bus.write_hilo_o));
`endif

        for (int i = 0; i < 20; i++) begin
            s = 1'($urandom);
            case ($urandom_range(0, 4))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom; b = $urandom_range(1, 20); end
                2: begin a = $urandom; b = 32'd0; end
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: begin a = $urandom; b = -$urandom_range(1, 300); end
            endcase
            run_op($sformatf("rand%0d", i), s, a, b);
        end
        bus.start_i = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
